fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage that produces the {PC, instruction} stream consumed by the fetch/decode pipeline register.
- Issues in-order requests to the instruction memory and tracks them in flight.
- Buffers returned words in a small FIFO and presents them downstream, honouring the downstream stall.
- Handles branch redirects, discarding stale in-flight responses.

Parameters:
- PCW, 32, PC / address width in bits.
- INSTRW, 16, instruction width in bits; PC step = INSTRW/8 bytes.
- DEPTH, 2, instruction FIFO entries; also the cap on (in-flight requests + buffered entries); power of two, at least 2.
- RESET_PC, 0, fetch address after reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous active-high reset.
- stall  in  1  downstream hold; head entry not consumed this cycle.
- redirect  in  1  branch/flush; restart fetch at redirect_pc.
- redirect_pc  in  PCW  new fetch address.
- imem_req  out  1  request valid.
- imem_addr  out  PCW  request byte address.
- imem_ready  in  1  memory accepts request; fire = imem_req & imem_ready.
- imem_rvalid  in  1  response valid; in order, one per fire, no backpressure, at least 1 cycle after its fire.
- imem_rdata  in  INSTRW  response word.
- fetch_valid  out  1  PC_out/instr_out hold a real instruction.
- PC_out  out  PCW  PC of head instruction.
- instr_out  out  INSTRW  head instruction.

Behaviour:
- Reset (async, immediate): fetch_pc = RESET_PC; resp_pc = RESET_PC; inflight = 0; drop_cnt = 0; FIFO empty. Outputs: imem_req = 0, imem_addr = RESET_PC, fetch_valid = 0, PC_out = 0, instr_out = 0.
- Memory is reset together with this block; no pre-reset responses arrive.
- pop = fetch_valid & ~stall & ~redirect.
- Issue:
  - imem_req = ~redirect & (inflight + count - pop < DEPTH).
  - imem_addr = fetch_pc.
  - On fire: fetch_pc += INSTRW/8 (wraps mod 2^PCW); inflight++.
  - While imem_req is high and not ready, addr is held.
- Response, when imem_rvalid:
  - inflight--.
  - If drop_cnt > 0: discard the word, drop_cnt--.
  - Else: push {resp_pc, imem_rdata} to FIFO; resp_pc += INSTRW/8 (wraps).
  - The credit rule guarantees the FIFO is never full on a push; an overflow assertion is required in the bench.
- Output:
  - fetch_valid = FIFO non-empty.
  - PC_out/instr_out = head entry, or 0/0 when empty (bubble = NOP).
  - Head is removed on pop.
  - Push and pop in the same cycle are both honoured; count is unchanged.
- Redirect (highest priority, overrides stall, same cycle):
  - FIFO cleared; no pop.
  - imem_req forced 0.
  - fetch_pc = resp_pc = redirect_pc.
  - drop_cnt = inflight - imem_rvalid (the value after this cycle's response is retired), so every still-outstanding old response is discarded.
  - Requests resume next cycle even while drop_cnt > 0.
  - Back-to-back redirects: the latest wins; drop_cnt is recomputed each time.
- Latency:
  - 1-cycle memory (rvalid the cycle after fire): first fetch_valid 2 cycles after reset release.
  - Redirect at cycle N: req at N+1, fetch_valid at N+3.
  - Sustained throughput is 1 instruction/cycle with DEPTH >= 2 and 1-cycle memory.
- Stall held: FIFO fills, then imem_req drops once inflight + count = DEPTH. Head data stays stable.
- Invariants:
  - 0 <= inflight <= DEPTH.
  - drop_cnt <= inflight.
  - count + inflight <= DEPTH.

Test Plan:
- Reset release; 1-cycle memory; imem_rdata = address[15:0]; stall = 0 → fetch_valid from cycle 2. PC_out = 0,2,4,6… each cycle; instr_out equals its PC; imem_req continuous.
- Stall held 5 cycles with DEPTH = 2 → imem_req low after the FIFO holds 2 entries. PC_out/instr_out frozen. After release, sequence continues with no gap or duplicate.
- Redirect to 0x100 while 2 responses are in flight (3-cycle memory) → both old words are dropped. Next fetch_valid shows PC_out = 0x100, then 0x102; no stale PC appears.
- Redirect and stall together with FIFO full → FIFO emptied, fetch_valid = 0 next cycle. Fetch restarts at redirect_pc despite stall.
- fetch_pc = 0xFFFFFFFE, no stall → next PC_out = 0x00000000 (wrap).
- Async rst mid-stream (asserted between edges) → fetch_valid, imem_req and outputs go to 0 immediately. After release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: issues in-order memory requests under a credit limit,
// buffers returned words in a small FIFO and drops stale responses after a redirect.
module fetch_unit #(
    parameter int                PCW      = 32,
    parameter int                INSTRW   = 16,
    parameter int                DEPTH    = 2,
    parameter logic [PCW-1:0]    RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              redirect,
    input  logic [PCW-1:0]    redirect_pc,
    output logic              imem_req,
    output logic [PCW-1:0]    imem_addr,
    input  logic              imem_ready,
    input  logic              imem_rvalid,
    input  logic [INSTRW-1:0] imem_rdata,
    output logic              fetch_valid,
    output logic [PCW-1:0]    PC_out,
    output logic [INSTRW-1:0] instr_out
);

    localparam int PW   = $clog2(DEPTH);
    localparam int CW   = $clog2(DEPTH + 1);
    localparam int STEP = INSTRW / 8;

    localparam logic [CW:0]    DEPTH_C = (CW + 1)'(DEPTH);
    localparam logic [PCW-1:0] STEP_C  = PCW'(STEP);

    typedef struct packed {
        logic [PCW-1:0]    pc;
        logic [INSTRW-1:0] instr;
    } entry_t;

    entry_t            fifo_q [DEPTH];
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [CW-1:0]     inflight_q, inflight_d;
    logic [CW-1:0]     drop_cnt_q, drop_cnt_d;
    logic [PCW-1:0]    fetch_pc_q, fetch_pc_d;
    logic [PCW-1:0]    resp_pc_q, resp_pc_d;

    logic              push;
    logic              pop;
    logic              fire;
    logic [CW:0]       credit_used;

    assign fetch_valid = (count_q != '0);
    assign pop         = fetch_valid & ~stall & ~redirect;

    // Slots a popped head frees this cycle can be re-requested immediately.
    assign credit_used = {1'b0, inflight_q} + {1'b0, count_q} - {{CW{1'b0}}, pop};
    assign imem_req    = ~rst & ~redirect & (credit_used < DEPTH_C);
    assign imem_addr   = fetch_pc_q;
    assign fire        = imem_req & imem_ready;

    assign push        = imem_rvalid & (drop_cnt_q == '0) & ~redirect;

    assign PC_out      = fetch_valid ? fifo_q[rd_ptr_q].pc    : '0;
    assign instr_out   = fetch_valid ? fifo_q[rd_ptr_q].instr : '0;

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path leaves it unassigned (no latch).
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        inflight_d = inflight_q + CW'(fire) - CW'(imem_rvalid);
        drop_cnt_d = drop_cnt_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;

        if (redirect) begin
            // Everything still outstanding after this cycle's response belongs to the old path.
            fetch_pc_d = redirect_pc;
            resp_pc_d  = redirect_pc;
            drop_cnt_d = inflight_q - CW'(imem_rvalid);
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (fire) begin
                fetch_pc_d = fetch_pc_q + STEP_C;
            end
            if (imem_rvalid) begin
                if (drop_cnt_q != '0) begin
                    drop_cnt_d = drop_cnt_q - 1'b1;
                end else begin
                    resp_pc_d = resp_pc_q + STEP_C;
                end
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            inflight_q <= '0;
            drop_cnt_q <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            inflight_q <= inflight_d;
            drop_cnt_q <= drop_cnt_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // NOTE: FIFO storage is deliberately not reset; count_q alone decides which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= '{pc: resp_pc_q, instr: imem_rdata};
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: cycle-by-cycle vector tables against a
// fixed-latency in-order memory model whose data equals the low address bits.
module tb_fetch_unit;

    typedef struct {
        logic        stall;
        logic        redirect;
        logic [31:0] rpc;
        logic        v;
        logic [31:0] pc;
        logic [15:0] instr;
        logic        req;
        logic [31:0] addr;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [15:0] imem_rdata;
    logic        fetch_valid;
    logic [31:0] PC_out;
    logic [15:0] instr_out;

    int n_vec  = 0;
    int n_miss = 0;
    int mem_lat = 1;

    logic [3:0]  pipe_v;
    logic [31:0] pipe_a [4];

    always #5 clk = ~clk;

    fetch_unit #(
        .PCW(32), .INSTRW(16), .DEPTH(2), .RESET_PC(32'h0)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .fetch_valid(fetch_valid), .PC_out(PC_out), .instr_out(instr_out)
    );

    // Fixed-latency memory: response mem_lat cycles after the accepting edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_v <= '0;
            for (int k = 0; k < 4; k++) pipe_a[k] <= '0;
        end else begin
            pipe_v    <= {pipe_v[2:0], imem_req & imem_ready};
            pipe_a[0] <= imem_addr;
            for (int k = 1; k < 4; k++) pipe_a[k] <= pipe_a[k-1];
        end
    end

    assign imem_rvalid = pipe_v[mem_lat-1];
    assign imem_rdata  = imem_rvalid ? pipe_a[mem_lat-1][15:0] : 16'h0;

    always @(posedge clk) begin
        if (!rst && dut.push) begin
            assert (int'(dut.count_q) < 2) else $error("fifo overflow on push");
        end
    end

    function automatic vec_t mk(input logic s, input logic r, input logic [31:0] rpc,
                                input logic v, input logic [31:0] pc, input logic [15:0] ins,
                                input logic req, input logic [31:0] addr);
        vec_t t;
        t.stall = s; t.redirect = r; t.rpc = rpc;
        t.v = v; t.pc = pc; t.instr = ins; t.req = req; t.addr = addr;
        return t;
    endfunction

    task automatic check(input string name, input logic [81:0] act, input logic [81:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got v=%b req=%b addr=%h pc=%h instr=%h, want v=%b req=%b addr=%h pc=%h instr=%h",
                     name, act[81], act[80], act[79:48], act[47:16], act[15:0],
                     exp[81], exp[80], exp[79:48], exp[47:16], exp[15:0]);
        end
    endtask

    function automatic logic [81:0] obs();
        return {fetch_valid, imem_req, imem_addr, PC_out, instr_out};
    endfunction

    task automatic run_vec(input vec_t t, input string name);
        stall       = t.stall;
        redirect    = t.redirect;
        redirect_pc = t.rpc;
        #1;
        check(name, obs(), {t.v, t.req, t.addr, t.pc, t.instr});
        @(negedge clk);
    endtask

    vec_t t1 [27];
    vec_t t2 [13];

    initial begin
        // 1-cycle memory: stream, 5-cycle stall, redirect+stall with full FIFO, PC wrap.
        t1[0]  = mk(0, 0, 0,            0, 32'h0,        16'h0,    1, 32'h0);
        t1[1]  = mk(0, 0, 0,            0, 32'h0,        16'h0,    1, 32'h2);
        t1[2]  = mk(0, 0, 0,            1, 32'h0,        16'h0,    1, 32'h4);
        t1[3]  = mk(0, 0, 0,            1, 32'h2,        16'h2,    1, 32'h6);
        t1[4]  = mk(0, 0, 0,            1, 32'h4,        16'h4,    1, 32'h8);
        t1[5]  = mk(1, 0, 0,            1, 32'h6,        16'h6,    0, 32'ha);
        t1[6]  = mk(1, 0, 0,            1, 32'h6,        16'h6,    0, 32'ha);
        t1[7]  = mk(1, 0, 0,            1, 32'h6,        16'h6,    0, 32'ha);
        t1[8]  = mk(1, 0, 0,            1, 32'h6,        16'h6,    0, 32'ha);
        t1[9]  = mk(1, 0, 0,            1, 32'h6,        16'h6,    0, 32'ha);
        t1[10] = mk(0, 0, 0,            1, 32'h6,        16'h6,    1, 32'ha);
        t1[11] = mk(0, 0, 0,            1, 32'h8,        16'h8,    1, 32'hc);
        t1[12] = mk(0, 0, 0,            1, 32'ha,        16'ha,    1, 32'he);
        t1[13] = mk(0, 0, 0,            1, 32'hc,        16'hc,    1, 32'h10);
        t1[14] = mk(1, 0, 0,            1, 32'he,        16'he,    0, 32'h12);
        t1[15] = mk(1, 0, 0,            1, 32'he,        16'he,    0, 32'h12);
        t1[16] = mk(1, 1, 32'h200,      1, 32'he,        16'he,    0, 32'h12);
        t1[17] = mk(1, 0, 0,            0, 32'h0,        16'h0,    1, 32'h200);
        t1[18] = mk(1, 0, 0,            0, 32'h0,        16'h0,    1, 32'h202);
        t1[19] = mk(1, 0, 0,            1, 32'h200,      16'h200,  0, 32'h204);
        t1[20] = mk(0, 0, 0,            1, 32'h200,      16'h200,  1, 32'h204);
        t1[21] = mk(0, 0, 0,            1, 32'h202,      16'h202,  1, 32'h206);
        t1[22] = mk(0, 1, 32'hfffffffe, 1, 32'h204,      16'h204,  0, 32'h208);
        t1[23] = mk(0, 0, 0,            0, 32'h0,        16'h0,    1, 32'hfffffffe);
        t1[24] = mk(0, 0, 0,            0, 32'h0,        16'h0,    1, 32'h0);
        t1[25] = mk(0, 0, 0,            1, 32'hfffffffe, 16'hfffe, 1, 32'h2);
        t1[26] = mk(0, 0, 0,            1, 32'h0,        16'h0,    1, 32'h4);

        // 3-cycle memory: redirect to 0x100 with two old responses still in flight.
        t2[0]  = mk(0, 0, 0,            0, 32'h0,   16'h0,   1, 32'h0);
        t2[1]  = mk(0, 0, 0,            0, 32'h0,   16'h0,   1, 32'h2);
        t2[2]  = mk(0, 1, 32'h100,      0, 32'h0,   16'h0,   0, 32'h4);
        t2[3]  = mk(0, 0, 0,            0, 32'h0,   16'h0,   0, 32'h100);
        t2[4]  = mk(0, 0, 0,            0, 32'h0,   16'h0,   1, 32'h100);
        t2[5]  = mk(0, 0, 0,            0, 32'h0,   16'h0,   1, 32'h102);
        t2[6]  = mk(0, 0, 0,            0, 32'h0,   16'h0,   0, 32'h104);
        t2[7]  = mk(0, 0, 0,            0, 32'h0,   16'h0,   0, 32'h104);
        t2[8]  = mk(0, 0, 0,            1, 32'h100, 16'h100, 1, 32'h104);
        t2[9]  = mk(0, 0, 0,            1, 32'h102, 16'h102, 1, 32'h106);
        t2[10] = mk(0, 0, 0,            0, 32'h0,   16'h0,   0, 32'h108);
        t2[11] = mk(0, 0, 0,            0, 32'h0,   16'h0,   0, 32'h108);
        t2[12] = mk(0, 0, 0,            1, 32'h104, 16'h104, 1, 32'h108);

        stall = 1'b0; redirect = 1'b0; redirect_pc = '0; imem_ready = 1'b1;
        rst = 1'b0;
        #1 rst = 1'b1;
        #1 check("reset_state", obs(), {1'b0, 1'b0, 32'h0, 32'h0, 16'h0});
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 27; i++) run_vec(t1[i], $sformatf("lat1_c%0d", i));

        // Mid-stream asynchronous reset, asserted between clock edges.
        #1 check("pre_async_rst", obs(), {1'b1, 1'b1, 32'h6, 32'h2, 16'h2});
        #2 rst = 1'b1;
        #1 check("async_rst_now", obs(), {1'b0, 1'b0, 32'h0, 32'h0, 16'h0});
        mem_lat = 3;
        @(negedge clk);
        #1 check("async_rst_hold", obs(), {1'b0, 1'b0, 32'h0, 32'h0, 16'h0});
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) run_vec(t2[i], $sformatf("lat3_c%0d", i));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
